axis_rr_arbiter_regs: RTL

- Parametrised successor to the single-stream AXI-Lite/AXI-Stream demo block.
- Merges NUM_CHANNELS AXI-Stream inputs onto one AXI-Stream output using packet-granular round-robin arbitration.
- An AXI-Lite slave provides channel enables, status and per-channel packet counters.
- Sits between multiple stream producers and one consumer; the same clock serves both AXI-Lite and AXIS.

---
 rtl/axis_rr_arbiter_regs.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/axis_rr_arbiter_regs.sv
// Packet-granular round-robin merge of NUM_CHANNELS AXI-Stream inputs onto one
// output, with an AXI-Lite slave for enables, status and per-channel packet counters.
module axis_rr_arbiter_regs #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int STROBE_WIDTH    = DATA_WIDTH / 8,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int NUM_CHANNELS    = 4
) (
    input  logic                                    i_axi_clk,
    input  logic                                    i_axi_rst,
    input  logic                                    i_awvalid,
    input  logic [ADDR_WIDTH-1:0]                   i_awaddr,
    output logic                                    o_awready,
    input  logic                                    i_wvalid,
    output logic                                    o_wready,
    input  logic [STROBE_WIDTH-1:0]                 i_wstrb,
    input  logic [DATA_WIDTH-1:0]                   i_wdata,
    output logic                                    o_bvalid,
    input  logic                                    i_bready,
    output logic [1:0]                              o_bresp,
    input  logic                                    i_arvalid,
    output logic                                    o_arready,
    input  logic [ADDR_WIDTH-1:0]                   i_araddr,
    output logic                                    o_rvalid,
    input  logic                                    i_rready,
    output logic [1:0]                              o_rresp,
    output logic [DATA_WIDTH-1:0]                   o_rdata,
    input  logic [NUM_CHANNELS-1:0]                 i_axis_in_tvalid,
    output logic [NUM_CHANNELS-1:0]                 o_axis_in_tready,
    input  logic [NUM_CHANNELS-1:0]                 i_axis_in_tlast,
    input  logic [NUM_CHANNELS-1:0]                 i_axis_in_tuser,
    input  logic [NUM_CHANNELS*AXIS_DATA_WIDTH-1:0] i_axis_in_tdata,
    output logic                                    o_axis_out_tvalid,
    input  logic                                    i_axis_out_tready,
    output logic                                    o_axis_out_tlast,
    output logic                                    o_axis_out_tuser,
    output logic [AXIS_DATA_WIDTH-1:0]              o_axis_out_tdata
);

    localparam int GW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_e;

    state_e                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d, last_grant_q;
    logic                    en_q;
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [31:0]             cnt_q [NUM_CHANNELS];
    logic                    bvalid_q, rvalid_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rd_mux;
    logic                    wr_fire, rd_fire, pkt_done, arb_found;
    logic [5:0]              wr_idx;
    logic [NUM_CHANNELS-1:0] req, clr;
    logic                    unused_sig;

    assign unused_sig = ^{i_awaddr, i_araddr, i_wdata, i_wstrb};

    // Ready is combinational so address and data are always taken together.
    assign wr_fire   = i_awvalid & i_wvalid & ~bvalid_q & ~i_axi_rst;
    assign rd_fire   = i_arvalid & ~rvalid_q & ~i_axi_rst;
    assign wr_idx    = i_awaddr[7:2];
    assign o_awready = wr_fire;
    assign o_wready  = wr_fire;
    assign o_bvalid  = bvalid_q;
    assign o_bresp   = '0;
    assign o_arready = rd_fire;
    assign o_rvalid  = rvalid_q;
    assign o_rresp   = '0;
    assign o_rdata   = rdata_q;

    always_comb begin
        clr = '0;
        if (wr_fire && wr_idx == 6'd2 && i_wstrb[0]) clr = i_wdata[NUM_CHANNELS-1:0];
    end

    always_comb begin
        rd_mux = '0;
        case (i_araddr[7:2])
            6'd0: begin
                rd_mux[0]                = en_q;
                rd_mux[8 +: NUM_CHANNELS] = mask_q;
            end
            6'd1: begin
                rd_mux[GW-1:0] = grant_q;
                rd_mux[8]      = (state_q == S_GRANT);
            end
            default: begin
                for (int unsigned c = 0; c < NUM_CHANNELS; c++)
                    if (i_araddr[7:2] == 6'(4 + c)) rd_mux = cnt_q[c];
            end
        endcase
    end

    always_comb begin
        o_axis_out_tvalid = 1'b0;
        o_axis_out_tlast  = 1'b0;
        o_axis_out_tuser  = 1'b0;
        o_axis_out_tdata  = '0;
        o_axis_in_tready  = '0;
        if (state_q == S_GRANT) begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                if (grant_q == GW'(c)) begin
                    o_axis_out_tvalid   = i_axis_in_tvalid[c];
                    o_axis_out_tlast    = i_axis_in_tlast[c];
                    o_axis_out_tuser    = i_axis_in_tuser[c];
                    o_axis_out_tdata    = i_axis_in_tdata[c*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                    o_axis_in_tready[c] = i_axis_out_tready;
                end
            end
        end
    end

    assign pkt_done = (state_q == S_GRANT) & o_axis_out_tvalid & i_axis_out_tready & o_axis_out_tlast;
    assign req      = i_axis_in_tvalid & mask_q & {NUM_CHANNELS{en_q}};

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        arb_found = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Scan starts one past the last winner, so it has lowest priority.
                for (int unsigned k = 1; k <= NUM_CHANNELS; k++) begin
                    if (!arb_found && req[(32'(last_grant_q) + k) % NUM_CHANNELS]) begin
                        arb_found = 1'b1;
                        grant_d   = GW'((32'(last_grant_q) + k) % NUM_CHANNELS);
                        state_d   = S_GRANT;
                    end
                end
            end
            S_GRANT: if (pkt_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_axi_clk) begin
        if (i_axi_rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_CHANNELS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (pkt_done) last_grant_q <= grant_q;
        end
    end

    always_ff @(posedge i_axi_clk) begin
        if (i_axi_rst) begin
            en_q     <= 1'b0;
            mask_q   <= '0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) cnt_q[c] <= '0;
        end else begin
            if (wr_fire && wr_idx == 6'd0) begin
                if (i_wstrb[0]) en_q   <= i_wdata[0];
                if (i_wstrb[1]) mask_q <= i_wdata[8 +: NUM_CHANNELS];
            end
            if (wr_fire)       bvalid_q <= 1'b1;
            else if (i_bready) bvalid_q <= 1'b0;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (i_rready) begin
                rvalid_q <= 1'b0;
            end
            // Clear takes precedence over a same-cycle increment.
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                if (clr[c])                             cnt_q[c] <= '0;
                else if (pkt_done && grant_q == GW'(c)) cnt_q[c] <= cnt_q[c] + 32'd1;
            end
        end
    end

endmodule
